// File: rtl/screen_scroll_ctrl.sv
// Shares the screen memory CPU port between the CPU and a clear / scroll-up-one-row engine.
// Optional macro SCROLL_CPU_PRIORITY_EN: CPU accesses steal cycles from a running operation.
module screen_scroll_ctrl #(
    parameter int Abits = 11,
    parameter int Dbits = 3,
    parameter int COLS  = 40,
    parameter int ROWS  = 30,
    parameter int FILL  = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cpu_req,
    input  logic             cpu_wr,
    input  logic [Abits-1:0] cpu_addr,
    input  logic [Dbits-1:0] cpu_din,
    output logic [Dbits-1:0] cpu_dout,
    output logic             cpu_wait,
    input  logic             clear_req,
    input  logic             scroll_req,
    output logic             busy,
    output logic             done,
    output logic             mem_wr,
    output logic [Abits-1:0] mem_addr,
    output logic [Dbits-1:0] mem_din,
    input  logic [Dbits-1:0] mem_dout
);

    typedef enum logic [2:0] {IDLE, CLR, RD, WR, FIL} state_t;

    localparam logic [Abits-1:0] LAST_CELL = Abits'(COLS * ROWS - 1);
    localparam logic [Abits-1:0] LAST_COPY = Abits'(COLS * (ROWS - 1) - 1);
    localparam logic [Abits-1:0] ROW_STEP  = Abits'(COLS);
    localparam logic [Dbits-1:0] FILL_CODE = Dbits'(FILL);

    state_t           state, state_next;
    logic [Abits-1:0] idx, idx_next;
    logic [Dbits-1:0] hold, hold_next;
    logic             done_r, done_next;
    logic             engine_busy;
    logic             stall;

    assign engine_busy = (state != IDLE);

    // A stolen cycle hands the port to the CPU and freezes the engine in place.
`ifdef SCROLL_CPU_PRIORITY_EN
    assign stall = engine_busy & cpu_req;
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            idx    <= '0;
            hold   <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            hold   <= hold_next;
            done_r <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        hold_next  = hold;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLR;
                    idx_next   = '0;
                end else if (scroll_req) begin
                    state_next = RD;
                    idx_next   = '0;
                end
            end
            CLR, FIL: begin
                idx_next = idx + 1'b1;
                if (idx == LAST_CELL) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            RD: begin
                hold_next  = mem_dout;
                state_next = WR;
            end
            WR: begin
                idx_next   = idx + 1'b1;
                state_next = (idx == LAST_COPY) ? FIL : RD;
            end
            default: state_next = IDLE;
        endcase
        if (stall) begin
            state_next = state;
            idx_next   = idx;
            hold_next  = hold;
            done_next  = 1'b0;
        end
    end

    always_comb begin
        mem_addr = cpu_addr;
        mem_din  = cpu_din;
        mem_wr   = cpu_req & cpu_wr;
        if (!stall) begin
            case (state)
                CLR, FIL: begin
                    mem_addr = idx;
                    mem_din  = FILL_CODE;
                    mem_wr   = 1'b1;
                end
                RD: begin
                    mem_addr = idx + ROW_STEP;
                    mem_din  = hold;
                    mem_wr   = 1'b0;
                end
                WR: begin
                    mem_addr = idx;
                    mem_din  = hold;
                    mem_wr   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = engine_busy;
    assign done     = done_r;
    assign cpu_wait = engine_busy & cpu_req & ~stall;
    assign cpu_dout = mem_dout;

endmodule

// File: tb/tb_screen_scroll_ctrl.sv
// Bench for screen_scroll_ctrl: a behavioural screen memory, directed operations, and a done-pulse scoreboard.
// Expectations follow SCROLL_CPU_PRIORITY_EN when it is defined.
module tb_screen_scroll_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_req = 1'b0;
    logic       cpu_wr = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic [2:0] cpu_din = '0;
    logic [2:0] cpu_dout;
    logic       cpu_wait;
    logic       clear_req = 1'b0;
    logic       scroll_req = 1'b0;
    logic       busy;
    logic       done;
    logic       mem_wr;
    logic [10:0] mem_addr;
    logic [2:0] mem_din;
    logic [2:0] mem_dout;

    logic [2:0] mem [0:2047];
    logic [2:0] exp_img [0:1199];
    logic       pre_req = 1'b0;
    logic [1:0] pre_mode = 2'd0;

    typedef struct {
        string name;
        int    cycles;
    } exp_t;
    exp_t exp_q [$];

    int assert_count = 0;
    int fail_count = 0;
    int busy_count = 0;

`ifdef SCROLL_CPU_PRIORITY_EN
    localparam int SCROLL_CYCLES = 2363;
    localparam int EXP_WAIT      = 0;
    localparam int EXP_CELL5     = 7;
    localparam int EXP_WR_STOLEN = 1;
`else
    localparam int SCROLL_CYCLES = 2360;
    localparam int EXP_WAIT      = 1;
    localparam int EXP_CELL5     = 1;
    localparam int EXP_WR_STOLEN = 0;
`endif

    screen_scroll_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .cpu_wait   (cpu_wait),
        .clear_req  (clear_req),
        .scroll_req (scroll_req),
        .busy       (busy),
        .done       (done),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always #5 clock = ~clock;

    // Screen memory: combinational read, registered write, plus a one-cycle bulk preload.
    assign mem_dout = mem[mem_addr];
    always @(posedge clock) begin
        if (pre_req) begin
            for (int i = 0; i < 2048; i++)
                mem[i] <= (pre_mode == 2'd1) ? 3'(i % 8) : 3'((i / 40) % 8);
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_din;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assert_count++;
        if (actual != expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkImage(input string name);
        int bad = 0;
        int first = 0;
        for (int i = 1199; i >= 0; i--) begin
            if (mem[i] !== exp_img[i]) begin
                bad++;
                first = i;
            end
        end
        assert_count++;
        if (bad != 0) begin
            fail_count++;
            $display("[TB] FAIL %s: %0d cells differ, first cell %0d got %0d expected %0d",
                     name, bad, first, mem[first], exp_img[first]);
        end
    endtask

    task automatic preload(input logic [1:0] mode);
        @(negedge clock);
        pre_mode = mode;
        pre_req  = 1'b1;
        @(negedge clock);
        pre_req  = 1'b0;
    endtask

    // Pulses the requests for one edge; returns at the first engine cycle.
    task automatic applyStimulus(input logic clr, input logic scr);
        @(negedge clock);
        clear_req  = clr;
        scroll_req = scr;
        @(negedge clock);
        clear_req  = 1'b0;
        scroll_req = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        assert_count++;
        if (done !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL %s: done not seen within %0d cycles", name, budget);
        end
        @(negedge clock);
        checkOutput({name, "_done_width"}, int'(done), 0);
        checkOutput({name, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic setScrollImage(input int written);
        for (int i = 0; i < 1200; i++) begin
            if (i < written)
                exp_img[i] = (i < 1160) ? 3'(((i / 40) + 1) % 8) : 3'd0;
            else
                exp_img[i] = 3'((i / 40) % 8);
        end
    endtask

    // Scoreboard side: measures busy length and matches each done pulse to a queued operation.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                busy_count = 0;
            end else begin
                if (busy) busy_count++;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        assert_count++;
                        fail_count++;
                        $display("[TB] FAIL unexpected_done: got done after %0d busy cycles, expected none",
                                 busy_count);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput(e.name, busy_count, e.cycles);
                    end
                    busy_count = 0;
                end
            end
        end
    endtask

    task automatic mainSequence();
        // Reset: engine idle, memory port follows the CPU.
        cpu_req  = 1'b1;
        cpu_wr   = 1'b1;
        cpu_addr = 11'd123;
        cpu_din  = 3'd5;
        repeat (2) @(negedge clock);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_cpu_wait", int'(cpu_wait), 0);
        checkOutput("reset_mem_wr", int'(mem_wr), 1);
        checkOutput("reset_mem_addr", int'(mem_addr), 123);
        checkOutput("reset_mem_din", int'(mem_din), 5);
        cpu_req = 1'b0;
        cpu_wr  = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        // Clear over an addr mod 8 pattern.
        preload(2'd1);
        cpu_addr = 11'd13;
        cpu_req  = 1'b1;
        #1;
        checkOutput("idle_cpu_read", int'(cpu_dout), 5);
        checkOutput("idle_cpu_wait", int'(cpu_wait), 0);
        cpu_req = 1'b0;
        exp_q.push_back('{"clear_cycles", 1200});
        applyStimulus(1'b1, 1'b0);
        checkOutput("clear_busy_rise", int'(busy), 1);
        waitDone("clear", 1300);
        for (int i = 0; i < 1200; i++) exp_img[i] = 3'd0;
        checkImage("clear_image");
        cpu_addr = 11'd13;
        cpu_req  = 1'b1;
        #1;
        checkOutput("cleared_cpu_read", int'(cpu_dout), 0);
        cpu_req = 1'b0;

        // Scroll with a CPU write to cell 5 arriving in cycles 100..102.
        preload(2'd2);
        exp_q.push_back('{"scroll_cycles", SCROLL_CYCLES});
        applyStimulus(1'b0, 1'b1);
        checkOutput("scroll_busy_rise", int'(busy), 1);
        repeat (100) @(negedge clock);
        cpu_req  = 1'b1;
        cpu_wr   = 1'b1;
        cpu_addr = 11'd5;
        cpu_din  = 3'd7;
        #1;
        checkOutput("stolen_mem_wr", int'(mem_wr), EXP_WR_STOLEN);
        for (int k = 0; k < 3; k++) begin
            checkOutput("busy_cpu_wait", int'(cpu_wait), EXP_WAIT);
            @(negedge clock);
            #1;
        end
        cpu_req = 1'b0;
        cpu_wr  = 1'b0;
        waitDone("scroll", 2500);
        setScrollImage(1200);
        exp_img[5] = 3'(EXP_CELL5);
        checkImage("scroll_image");

        // Simultaneous requests: clear wins, a scroll during busy is dropped.
        preload(2'd1);
        exp_q.push_back('{"both_req_cycles", 1200});
        applyStimulus(1'b1, 1'b1);
        repeat (300) @(negedge clock);
        scroll_req = 1'b1;
        @(negedge clock);
        scroll_req = 1'b0;
        waitDone("both_req", 1300);
        repeat (50) @(negedge clock);
        checkOutput("no_second_op", int'(busy), 0);
        for (int i = 0; i < 1200; i++) exp_img[i] = 3'd0;
        checkImage("both_req_image");

        // Reset at cycle 500 of a scroll: 249 cells already copied, no done.
        preload(2'd2);
        applyStimulus(1'b0, 1'b1);
        repeat (499) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        setScrollImage(249);
        checkImage("abort_image");
        exp_q.push_back('{"post_abort_clear_cycles", 1200});
        applyStimulus(1'b1, 1'b0);
        waitDone("post_abort_clear", 1300);
        for (int i = 0; i < 1200; i++) exp_img[i] = 3'd0;
        checkImage("post_abort_image");

        repeat (5) @(negedge clock);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        $display("[TB] screen_scroll_ctrl bench start");
        fork
            monitor();
            mainSequence();
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
